// File: rtl/gemm_pkg.sv
// gemm_pkg: shared types and default widths for the GEMM accelerator control path.
// Exports: ctrl_state_e (loop FSM states), mac_ctrl_t (per-cycle MAC/write strobes),
// and default width constants used as parameter defaults by the blocks.
package gemm_pkg;
    localparam int InDataWidth   = 8;
    localparam int OutDataWidth  = 32;
    localparam int AddrWidth     = 12;
    localparam int SizeAddrWidth = 8;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} ctrl_state_e;

    typedef struct packed {
        logic                 valid;
        logic                 clear;
        logic                 last;
        logic [AddrWidth-1:0] c_addr;
    } mac_ctrl_t;
endpackage

// File: rtl/gemm_ctrl_delay.sv
// gemm_ctrl_delay: fixed-depth shift register for mac_ctrl_t, cleared on reset.
// Ports: clk, rst (sync, active high), d (entry), q (entry delayed by Depth cycles).
module gemm_ctrl_delay
    import gemm_pkg::*;
#(
    parameter int Depth = 1
) (
    input  logic      clk,
    input  logic      rst,
    input  mac_ctrl_t d,
    output mac_ctrl_t q
);
    mac_ctrl_t pipe [Depth];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < Depth; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[Depth-1];
endmodule

// File: rtl/gemm_loop_ctrl.sv
// gemm_loop_ctrl: m/n/k loop-nest walker driving SRAM A/B reads, MAC strobes and C writes.
// Ports: clk_i/rst_i (sync active-high reset), start_i + M/K/N_size_i (job request),
// sram_a/b_addr_o (read addresses), mac_valid/clear/last_o (MAC strobes, one cycle after
// the address), sram_c_addr_o/sram_c_we_o (result write), busy_o, done_o (completion pulse).
module gemm_loop_ctrl
    import gemm_pkg::*;
#(
    parameter int AddrWidth     = 12,
    parameter int SizeAddrWidth = 8,
    parameter int MacLatency    = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [SizeAddrWidth-1:0] M_size_i,
    input  logic [SizeAddrWidth-1:0] K_size_i,
    input  logic [SizeAddrWidth-1:0] N_size_i,
    output logic [AddrWidth-1:0]     sram_a_addr_o,
    output logic [AddrWidth-1:0]     sram_b_addr_o,
    output logic                     mac_valid_o,
    output logic                     mac_clear_o,
    output logic                     mac_last_o,
    output logic [AddrWidth-1:0]     sram_c_addr_o,
    output logic                     sram_c_we_o,
    output logic                     busy_o,
    output logic                     done_o
);
    localparam int AW = AddrWidth;
    localparam int SW = SizeAddrWidth;
    localparam int PW = $bits(mac_ctrl_t) - 3;
    localparam int DW = $clog2(MacLatency + 1);

    ctrl_state_e     state, nxt;
    logic [SW-1:0]   m_sz, k_sz, n_sz, m, n, k;
    logic [AW-1:0]   a_row, b_addr, c_cnt;
    logic [DW-1:0]   drain;
    logic            done_q;
    logic            accept, zero, issue, k_last, n_last, m_last, job_end, drain_end;
    mac_ctrl_t       s1_nxt, s1, wr;
    logic            unused_wr_clear;

    // done_q marks the pulse cycle, already back in IDLE; start is not taken there.
    assign accept    = state == IDLE && start_i && !done_q;
    assign zero      = M_size_i == '0 || K_size_i == '0 || N_size_i == '0;
    assign issue     = state == RUN;
    assign k_last    = k == k_sz - SW'(1);
    assign n_last    = n == n_sz - SW'(1);
    assign m_last    = m == m_sz - SW'(1);
    assign job_end   = k_last && n_last && m_last;
    assign drain_end = drain == DW'(MacLatency - 1);

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = accept ? (zero ? DONE : RUN) : IDLE;
            RUN:     nxt = job_end ? DRAIN : RUN;
            DRAIN:   nxt = drain_end ? DONE : DRAIN;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            done_q <= 1'b0;
            drain  <= '0;
        end else begin
            state  <= nxt;
            done_q <= state == DONE;
            drain  <= state == DRAIN ? drain + DW'(1) : '0;
        end
    end

    // Incremental address generation: a = row base + k, b strides by N, c counts elements.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m_sz   <= '0;
            k_sz   <= '0;
            n_sz   <= '0;
            m      <= '0;
            n      <= '0;
            k      <= '0;
            a_row  <= '0;
            b_addr <= '0;
            c_cnt  <= '0;
        end else if (accept) begin
            m_sz   <= M_size_i;
            k_sz   <= K_size_i;
            n_sz   <= N_size_i;
            m      <= '0;
            n      <= '0;
            k      <= '0;
            a_row  <= '0;
            b_addr <= '0;
            c_cnt  <= '0;
        end else if (issue) begin
            if (k_last) begin
                k      <= '0;
                c_cnt  <= c_cnt + AW'(1);
                b_addr <= n_last ? '0 : AW'(n) + AW'(1);
                n      <= n_last ? '0 : n + SW'(1);
                if (n_last) begin
                    m     <= m + SW'(1);
                    a_row <= a_row + AW'(k_sz);
                end
            end else begin
                k      <= k + SW'(1);
                b_addr <= b_addr + AW'(n_sz);
            end
        end
    end

    always_comb begin
        s1_nxt        = '0;
        s1_nxt.valid  = issue;
        s1_nxt.clear  = issue && k == '0;
        s1_nxt.last   = issue && k_last;
        s1_nxt.c_addr = (issue && k_last) ? PW'(c_cnt) : '0;
    end

    // Stage 1 lines up with the SRAM read latency; the second delay covers the MAC.
    gemm_ctrl_delay #(.Depth(1)) u_rd_dly (
        .clk (clk_i),
        .rst (rst_i),
        .d   (s1_nxt),
        .q   (s1)
    );

    gemm_ctrl_delay #(.Depth(MacLatency)) u_wr_dly (
        .clk (clk_i),
        .rst (rst_i),
        .d   (s1),
        .q   (wr)
    );

    assign unused_wr_clear = wr.clear;

    assign sram_a_addr_o = issue ? a_row + AW'(k) : '0;
    assign sram_b_addr_o = issue ? b_addr : '0;
    assign mac_valid_o   = s1.valid;
    assign mac_clear_o   = s1.clear;
    assign mac_last_o    = s1.last;
    assign sram_c_we_o   = wr.valid && wr.last;
    assign sram_c_addr_o = sram_c_we_o ? AW'(wr.c_addr) : '0;
    assign busy_o        = state != IDLE || done_q;
    assign done_o        = done_q;
endmodule

// File: tb/tb_gemm_loop_ctrl.sv
// tb_gemm_loop_ctrl: directed bench for gemm_loop_ctrl with SRAM/MAC models and golden GEMM.
module tb_gemm_loop_ctrl;
    logic        clk, rst, clr_c;
    logic        start [2];
    logic [7:0]  msz [2], ksz [2], nsz [2];
    logic [11:0] a_addr [2], b_addr [2], c_addr [2];
    logic        mv [2], mc [2], ml [2], we [2], busy [2], done [2];
    logic signed [7:0] mem_a [4096], mem_b [4096];
    int          gold [64];
    int          tests = 0, fails = 0;
    int          ea [8] = '{0, 1, 0, 1, 2, 3, 2, 3};
    int          eb [8] = '{0, 2, 1, 3, 0, 2, 1, 3};

    gemm_loop_ctrl #(.AddrWidth(12), .SizeAddrWidth(8), .MacLatency(1)) u1 (
        .clk_i(clk), .rst_i(rst), .start_i(start[0]),
        .M_size_i(msz[0]), .K_size_i(ksz[0]), .N_size_i(nsz[0]),
        .sram_a_addr_o(a_addr[0]), .sram_b_addr_o(b_addr[0]),
        .mac_valid_o(mv[0]), .mac_clear_o(mc[0]), .mac_last_o(ml[0]),
        .sram_c_addr_o(c_addr[0]), .sram_c_we_o(we[0]),
        .busy_o(busy[0]), .done_o(done[0])
    );

    gemm_loop_ctrl #(.AddrWidth(12), .SizeAddrWidth(8), .MacLatency(2)) u2 (
        .clk_i(clk), .rst_i(rst), .start_i(start[1]),
        .M_size_i(msz[1]), .K_size_i(ksz[1]), .N_size_i(nsz[1]),
        .sram_a_addr_o(a_addr[1]), .sram_b_addr_o(b_addr[1]),
        .mac_valid_o(mv[1]), .mac_clear_o(mc[1]), .mac_last_o(ml[1]),
        .sram_c_addr_o(c_addr[1]), .sram_c_we_o(we[1]),
        .busy_o(busy[1]), .done_o(done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM with 1-cycle read, MAC accumulator, extra result stage for the latency-2 instance.
    for (genvar g = 0; g < 2; g++) begin : g_mdl
        logic signed [7:0] ra, rb;
        int acc, acc_d, mac_out;
        int mem_c [64];
        assign mac_out = (g == 0) ? acc : acc_d;
        always @(posedge clk) begin
            ra    <= mem_a[a_addr[g]];
            rb    <= mem_b[b_addr[g]];
            acc_d <= acc;
            if (mv[g]) acc <= mc[g] ? int'(ra) * int'(rb) : acc + int'(ra) * int'(rb);
            if (clr_c) begin
                for (int i = 0; i < 64; i++) mem_c[i] <= 0;
            end else if (we[g]) begin
                mem_c[c_addr[g][5:0]] <= mac_out;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] ctl(input int i);
        return {busy[i], done[i], we[i], ml[i], mc[i], mv[i]};
    endfunction

    task automatic go(input int i, input int mm, input int kk, input int nn);
        start[i] = 1'b1;
        msz[i]   = 8'(mm);
        ksz[i]   = 8'(kk);
        nsz[i]   = 8'(nn);
    endtask

    initial begin
        logic [5:0] e;
        int nw, nd, d1, d2, dc, lw, bad;
        rst = 1'b1;
        clr_c = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0;
            msz[i] = '0;
            ksz[i] = '0;
            nsz[i] = '0;
        end
        for (int i = 0; i < 4096; i++) begin
            mem_a[i] = 8'($urandom);
            mem_b[i] = 8'($urandom);
        end
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                gold[r*8+c] = 0;
                for (int q = 0; q < 8; q++) gold[r*8+c] += int'(mem_a[r*8+q]) * int'(mem_b[q*8+c]);
            end
        repeat (3) step();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_ctl%0d", i), ctl(i), 0);
            chk($sformatf("rst_a%0d", i), a_addr[i], 0);
            chk($sformatf("rst_b%0d", i), b_addr[i], 0);
            chk($sformatf("rst_c%0d", i), c_addr[i], 0);
        end
        rst = 1'b0;
        step();

        // 2x2x2, sizes changed after start must not matter
        go(0, 2, 2, 2);
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c == 1) begin
                start[0] = 1'b0;
                msz[0] = 8'd3;
                ksz[0] = 8'd3;
                nsz[0] = 8'd3;
            end
            e = {c <= 11, c == 11, c == 4 || c == 6 || c == 8 || c == 10,
                 c == 3 || c == 5 || c == 7 || c == 9, c == 2 || c == 4 || c == 6 || c == 8,
                 c >= 2 && c <= 9};
            chk($sformatf("t1_ctl@%0d", c), ctl(0), e);
            chk($sformatf("t1_c@%0d", c), c_addr[0], e[3] ? (c - 4) / 2 : 0);
            if (c <= 8) begin
                chk($sformatf("t1_a@%0d", c), a_addr[0], ea[c-1]);
                chk($sformatf("t1_b@%0d", c), b_addr[0], eb[c-1]);
            end
        end

        // 1x1x1
        go(0, 1, 1, 1);
        for (int c = 1; c <= 5; c++) begin
            step();
            if (c == 1) begin
                start[0] = 1'b0;
                chk("t2_a", a_addr[0], 0);
                chk("t2_b", b_addr[0], 0);
            end
            e = {c <= 4, c == 4, c == 3, c == 2, c == 2, c == 2};
            chk($sformatf("t2_ctl@%0d", c), ctl(0), e);
            chk($sformatf("t2_c@%0d", c), c_addr[0], 0);
        end

        // K=0 with M=N=4
        go(0, 4, 0, 4);
        for (int c = 1; c <= 4; c++) begin
            step();
            if (c == 1) start[0] = 1'b0;
            e = {c <= 2, c == 2, 4'b0};
            chk($sformatf("t3_ctl@%0d", c), ctl(0), e);
        end

        // start held high: one job, then a second only after returning to IDLE
        go(0, 2, 2, 2);
        nw = 0;
        nd = 0;
        d1 = -1;
        d2 = -1;
        for (int c = 1; c <= 30; c++) begin
            step();
            if (c == 15) start[0] = 1'b0;
            if (c == 12) chk("t4_busy12", busy[0], 0);
            if (we[0]) begin
                chk($sformatf("t4_caddr%0d", nw), c_addr[0], nw % 4);
                nw++;
            end
            if (done[0]) begin
                if (nd == 0) d1 = c;
                if (nd == 1) d2 = c;
                nd++;
            end
        end
        chk("t4_writes", nw, 8);
        chk("t4_dones", nd, 2);
        chk("t4_done1", d1, 11);
        chk("t4_done2", d2, 23);

        // reset at cycle 5 of an 8x8x8 run
        go(0, 8, 8, 8);
        for (int c = 1; c <= 5; c++) begin
            step();
            if (c == 1) start[0] = 1'b0;
        end
        rst = 1'b1;
        step();
        chk("t5_ctl", ctl(0), 0);
        chk("t5_a", a_addr[0], 0);
        chk("t5_b", b_addr[0], 0);
        chk("t5_c", c_addr[0], 0);
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 600; c++) begin
            step();
            if (ctl(0) != 0 || a_addr[0] != 0 || b_addr[0] != 0 || c_addr[0] != 0) bad++;
        end
        chk("t5_quiet", bad, 0);

        // fresh 8x8x8, latency 1, against golden
        clr_c = 1'b1;
        step();
        clr_c = 1'b0;
        go(0, 8, 8, 8);
        dc = -1;
        for (int c = 1; c <= 520; c++) begin
            step();
            if (c == 1) start[0] = 1'b0;
            if (done[0]) dc = c;
        end
        chk("t5_done", dc, 515);
        for (int i = 0; i < 64; i++) chk($sformatf("t5_mem%0d", i), g_mdl[0].mem_c[i], gold[i]);

        // 8x8x8, latency 2
        clr_c = 1'b1;
        step();
        clr_c = 1'b0;
        go(1, 8, 8, 8);
        nw = 0;
        dc = -1;
        lw = -1;
        for (int c = 1; c <= 520; c++) begin
            step();
            if (c == 1) start[1] = 1'b0;
            if (we[1]) begin
                chk($sformatf("t6_caddr%0d", nw), c_addr[1], nw);
                chk($sformatf("t6_wcyc%0d", nw), c, 11 + 8 * nw);
                lw = c;
                nw++;
            end
            if (done[1]) dc = c;
        end
        chk("t6_writes", nw, 64);
        chk("t6_last", lw, 515);
        chk("t6_done", dc, 516);
        for (int i = 0; i < 64; i++) chk($sformatf("t6_mem%0d", i), g_mdl[1].mem_c[i], gold[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/gemm_loop_ctrl.md
Name: gemm_loop_ctrl

Overview:
- Loop/address controller sitting directly upstream of the single-MAC datapath inside gemm_accelerator_top.
- Latches M/K/N on start and walks the m (outer), n (middle), k (inner) loop nest with one MAC operation per cycle.
- Drives SRAM A/B read addresses, and MAC valid/clear/last strobes aligned to the 1-cycle SRAM read latency.
- Drives the C write address and write enable, aligned to the MAC result.

Parameters:
- AddrWidth, 12, SRAM address width.
- SizeAddrWidth, 8, width of the M/K/N size inputs.
- MacLatency, 1, cycles from mac_last_o to the accumulated result being valid at the MAC output (≥1).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  start request, sampled only in IDLE.
- M_size_i  in  SizeAddrWidth  rows of A/C.
- K_size_i  in  SizeAddrWidth  inner dimension.
- N_size_i  in  SizeAddrWidth  columns of B/C.
- sram_a_addr_o  out  AddrWidth  A read address, m*K+k.
- sram_b_addr_o  out  AddrWidth  B read address, k*N+n.
- mac_valid_o  out  1  SRAM read data valid for the MAC this cycle.
- mac_clear_o  out  1  first k of an output element; MAC loads the product instead of accumulating.
- mac_last_o  out  1  last k of an output element.
- sram_c_addr_o  out  AddrWidth  C write address, m*N+n.
- sram_c_we_o  out  1  C write enable.
- busy_o  out  1  high from start acceptance until the done pulse inclusive.
- done_o  out  1  one-cycle completion pulse.

Behaviour:
- Reset: all outputs 0, FSM IDLE, counters and pipeline cleared. Reset mid-operation aborts immediately: no further writes, no done.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start_i=1 latches the sizes and asserts busy_o from the next cycle.
  - If any size is 0, go to DONE (no reads, no writes); otherwise go to RUN.
- RUN:
  - Each cycle issues one (m,n,k); k increments, wrapping to 0 at K-1 with n++; n wraps at N-1 with m++.
  - Leave for DRAIN after issuing (M-1,N-1,K-1).
- Addresses are computed incrementally with adders only, no multipliers:
  - a_row_base += K per m.
  - b addr += N per k; restarts at n when k wraps.
  - c addr increments by 1 per output element.
- All address arithmetic wraps modulo 2^AddrWidth. The caller guarantees M*K, K*N, M*N ≤ 2^AddrWidth.
- Pipeline alignment:
  - Address issued in cycle t → mac_valid_o, mac_clear_o (k==0) and mac_last_o (k==K-1) in cycle t+1.
  - sram_c_we_o and sram_c_addr_o in cycle t+1+MacLatency for the issue where k==K-1.
  - sram_c_addr_o holds 0 when sram_c_we_o=0.
- K==1: clear and last are asserted together.
- DRAIN: wait until the pipeline is empty (the last write has been issued), then go to DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- Timing: with start sampled at cycle 0, the first address is at cycle 1, the last write at cycle M*N*K+1+MacLatency, and done at cycle M*N*K+2+MacLatency.
- start_i is ignored while not in IDLE. start_i high in the DONE cycle is also ignored; it must be re-sampled in IDLE.
- Sizes are latched at start; input changes during RUN have no effect.
- Zero-size job: done_o at cycle 2 (IDLE → DONE → pulse). No reads, no writes.

Decomposition:
- Shared package gemm_pkg holds:
  - the ctrl_state_e enum (IDLE, RUN, DRAIN, DONE);
  - default width constants (InDataWidth=8, OutDataWidth=32, AddrWidth=12, SizeAddrWidth=8);
  - struct mac_ctrl_t {valid, clear, last, c_addr}.
- Sub-module gemm_ctrl_delay: parameterised-depth shift register for mac_ctrl_t, reset to 0. It delays the last/c_addr pair by MacLatency to produce the write strobe.

Test Plan:
- M=K=N=2, MacLatency=1, start at cycle 0:
  - A addresses 0,1,0,1,2,3,2,3 and B addresses 0,2,1,3,0,2,1,3 in cycles 1–8;
  - clear in cycles 2,4,6,8 and last in cycles 3,5,7,9;
  - writes to C 0,1,2,3 in cycles 4,6,8,10;
  - done in cycle 11.
- M=K=N=1: one address pair (0,0) at cycle 1; clear and last together at cycle 2; write C[0] at cycle 3; done at cycle 4.
- K=0 (M=N=4): no valid or we ever; done at cycle 2; busy_o high in cycles 1–2.
- start_i held high through a 2x2x2 run and beyond: exactly one job, then a second job starts only after returning to IDLE, with no duplicate writes.
- rst_i asserted at cycle 5 of an 8x8x8 run:
  - all outputs 0 from the next cycle, no done;
  - a fresh 8x8x8 run then matches the golden gemm result (random int8 A/B).
- 8x8x8 with MacLatency=2:
  - 64 writes, C addresses 0..63 in order, one every 8 cycles;
  - last write at cycle 515, done at cycle 516;
  - memory contents match the golden model.
